// File: rtl/csa_accum_pipe_if.sv
// Handshake bundle for csa_accum_pipe: operand beats in, resolved vector sums out.
interface csa_accum_pipe_if #(
   parameter int IN_W   = 16,
   parameter int NUM_IN = 4,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_IN*IN_W-1:0]   in_data;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic [ACC_W-1:0]         out_data;
   logic [LEN_W-1:0]         out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/csa_accum_pipe.sv
// Multi-operand carry-save accumulator. Each beat's NUM_IN signed operands are
// reduced to a sum/carry pair by a 3:2 compressor chain, folded into a carry-save
// accumulator {S,C}, and resolved with one carry-propagate add on the last beat.
// Optional macro CSA_ACCUM_PIPE_EN inserts a register between the tree and the
// accumulator (adds the DRAIN state, latency +1, throughput unchanged).
//
// state   | meaning
// ACC     | accepting beats, folding tree output into {S,C}
// DRAIN   | pipe build only: last tree register folds into {S,C}
// RESOLVE | out_data <= S+C, out_count <= count
// OUT     | result presented, waiting for out_ready
module csa_accum_pipe #(
   parameter int IN_W   = 16,
   parameter int NUM_IN = 4,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   csa_accum_pipe_if.slave   bus
);

   typedef enum logic [1:0] {ACC, DRAIN, RESOLVE, OUT} state_t;

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  acc_s, acc_c;
   logic [ACC_W-1:0]  tree_s, tree_c;
   logic [ACC_W-1:0]  add_s, add_c;
   logic [ACC_W-1:0]  fold_s, fold_c;
   logic              add_v;
   logic              accept;
   logic [LEN_W-1:0]  count;
   logic [ACC_W-1:0]  res_data;
   logic [LEN_W-1:0]  res_count;

   function automatic logic [ACC_W-1:0] ext_op(input logic [NUM_IN*IN_W-1:0] d, input int k);
      logic [IN_W-1:0] v;
      v = d[k*IN_W +: IN_W];
      return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
   endfunction

   // 3:2 compressor; carry bit out of the top position is dropped (modulo arithmetic)
   function automatic logic [2*ACC_W-1:0] csa3(input logic [ACC_W-1:0] a, b, c);
      logic [ACC_W-1:0] s, m;
      s = a ^ b ^ c;
      m = (a & b) | (a & c) | (b & c);
      return {s, m[ACC_W-2:0], 1'b0};
   endfunction

   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.in_ready  = (state == ACC);
   assign bus.out_valid = (state == OUT);
   assign bus.out_data  = res_data;
   assign bus.out_count = res_count;

   // reduce the beat's operands to one sum/carry pair
   always_comb begin
      logic [ACC_W-1:0] op;
      tree_s = ext_op(bus.in_data, 0);
      tree_c = ext_op(bus.in_data, 1);
      op     = '0;
      for (int k = 2; k < NUM_IN; k++) begin
         op = ext_op(bus.in_data, k);
         {tree_s, tree_c} = csa3(tree_s, tree_c, op);
      end
   end

`ifdef CSA_ACCUM_PIPE_EN
   logic [ACC_W-1:0] tr_s, tr_c;
   logic             tr_v;

   // tree output register with its own valid bit
   always_ff @(posedge clk) begin
      if (rst) begin
         tr_s <= '0;
         tr_c <= '0;
         tr_v <= 1'b0;
      end else begin
         tr_s <= tree_s;
         tr_c <= tree_c;
         tr_v <= accept;
      end
   end

   assign add_s = tr_s;
   assign add_c = tr_c;
   assign add_v = tr_v;
`else
   assign add_s = tree_s;
   assign add_c = tree_c;
   assign add_v = accept;
`endif

   // 4:2 fold of the addend pair into the accumulator, as two 3:2 stages
   always_comb begin
      logic [ACC_W-1:0] p_s, p_c;
      {p_s, p_c}       = csa3(acc_s, acc_c, add_s);
      {fold_s, fold_c} = csa3(p_s, p_c, add_c);
   end

   // carry-save accumulator and saturating beat counter
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_s <= '0;
         acc_c <= '0;
         count <= '0;
      end else if (state == OUT && bus.out_ready) begin
         acc_s <= '0;
         acc_c <= '0;
         count <= '0;
      end else begin
         if (add_v) begin
            acc_s <= fold_s;
            acc_c <= fold_c;
         end
         if (accept && count != '1)
            count <= count + LEN_W'(1);
      end
   end

   // single carry-propagate resolve into the held result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data  <= '0;
         res_count <= '0;
      end else if (state == RESOLVE) begin
         res_data  <= acc_s + acc_c;
         res_count <= count;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ACC;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ACC: begin
            if (accept && bus.in_last) begin
`ifdef CSA_ACCUM_PIPE_EN
               state_nxt = DRAIN;
`else
               state_nxt = RESOLVE;
`endif
            end
         end
         DRAIN:   state_nxt = RESOLVE;
         RESOLVE: state_nxt = OUT;
         OUT:     if (bus.out_ready) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

endmodule

// File: tb/tb_csa_accum_pipe.sv
// Directed bench for csa_accum_pipe: default-parameter instance plus a narrow
// instance (ACC_W=20, LEN_W=3) for wrap and count saturation.
module tb_csa_accum_pipe;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   csa_accum_pipe_if #(.IN_W(16), .NUM_IN(4), .ACC_W(32), .LEN_W(8)) b0 ();
   csa_accum_pipe_if #(.IN_W(16), .NUM_IN(4), .ACC_W(20), .LEN_W(3)) b1 ();

   csa_accum_pipe #(.IN_W(16), .NUM_IN(4), .ACC_W(32), .LEN_W(8)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0.slave)
   );

   csa_accum_pipe #(.IN_W(16), .NUM_IN(4), .ACC_W(20), .LEN_W(3)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

`ifdef CSA_ACCUM_PIPE_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pack4(input int a, b, c, d);
      logic [15:0] x0, x1, x2, x3;
      x0 = 16'(a); x1 = 16'(b); x2 = 16'(c); x3 = 16'(d);
      return {x3, x2, x1, x0};
   endfunction

   // waits (bounded) for out_valid on the selected instance; returns -1 on timeout
   task automatic wait_out(input int which, output int cyc);
      cyc = -1;
      for (int i = 0; i < 30; i++) begin
         if ((which == 0) ? b0.out_valid : b1.out_valid) begin
            cyc = i;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", b0.out_valid); end
      checks++; if (b0.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %0h want 0", b0.out_data); end
      checks++; if (b0.out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", b0.out_count); end
      checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %0b want 0", b1.out_valid); end
      rst = 1'b0;
      tick();
      checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", b0.in_ready); end
   endtask

   task automatic test_single();
      b0.in_data  = pack4(1, 2, 3, 4);
      b0.in_last  = 1'b1;
      b0.in_valid = 1'b1;
      checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %0b want 1", b0.in_ready); end
      tick();
      b0.in_valid = 1'b0;
      b0.in_last  = 1'b0;
      for (int i = 0; i < 1 + EXTRA; i++) begin
         checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid cycle %0d got %0b want 0", i + 1, b0.out_valid); end
         tick();
      end
      checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %0b want 1", b0.out_valid); end
      checks++; if (b0.out_data !== 32'd10) begin errors++; $display("FAIL single_data got %0d want 10", b0.out_data); end
      checks++; if (b0.out_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", b0.out_count); end
      b0.out_ready = 1'b1;
      tick();
      b0.out_ready = 1'b0;
      checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got %0b want 0", b0.out_valid); end
      checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_again got %0b want 1", b0.in_ready); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      for (int i = 0; i < 3; i++) begin
         b0.in_data  = pack4(-1, -1, -1, -1);
         b0.in_last  = (i == 2);
         b0.in_valid = 1'b1;
         checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat %0d got %0b want 1", i, b0.in_ready); end
         tick();
      end
      b0.in_valid = 1'b0;
      b0.in_last  = 1'b0;
      wait_out(0, cyc);
      checks++; if (cyc != EXTRA + 1) begin errors++; $display("FAIL b2b_latency got %0d want %0d", cyc, EXTRA + 1); end
      checks++; if (b0.out_data !== 32'hFFFF_FFF4) begin errors++; $display("FAIL b2b_data got %0h want fffffff4", b0.out_data); end
      checks++; if (b0.out_count !== 8'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", b0.out_count); end
      b0.out_ready = 1'b1;
      tick();
      b0.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int cyc;
      b0.in_data  = pack4(2, 3, 0, 0);
      b0.in_last  = 1'b1;
      b0.in_valid = 1'b1;
      tick();
      b0.in_data  = pack4(100, 200, 300, 400);
      b0.in_last  = 1'b1;
      wait_out(0, cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL bp_timeout got %0d want >=0", cyc); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 32'd5 || b0.out_count !== 8'd1 || b0.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got v=%0b d=%0d n=%0d rdy=%0b want v=1 d=5 n=1 rdy=0",
                     i, b0.out_valid, b0.out_data, b0.out_count, b0.in_ready);
         end
         tick();
      end
      b0.in_valid  = 1'b0;
      b0.in_last   = 1'b0;
      b0.out_ready = 1'b1;
      tick();
      b0.out_ready = 1'b0;
      b0.in_data  = pack4(7, 0, 0, 0);
      b0.in_last  = 1'b1;
      b0.in_valid = 1'b1;
      tick();
      b0.in_valid = 1'b0;
      b0.in_last  = 1'b0;
      wait_out(0, cyc);
      checks++; if (b0.out_data !== 32'd7) begin errors++; $display("FAIL bp_next_data got %0d want 7", b0.out_data); end
      checks++; if (b0.out_count !== 8'd1) begin errors++; $display("FAIL bp_next_count got %0d want 1", b0.out_count); end
      b0.out_ready = 1'b1;
      tick();
      b0.out_ready = 1'b0;
   endtask

   task automatic test_wrap_saturate();
      int cyc;
      for (int i = 0; i < 9; i++) begin
         b1.in_data  = pack4(32767, 32767, 32767, 32767);
         b1.in_last  = (i == 8);
         b1.in_valid = 1'b1;
         tick();
      end
      b1.in_valid = 1'b0;
      b1.in_last  = 1'b0;
      wait_out(1, cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL wrap_timeout got %0d want >=0", cyc); end
      checks++; if (b1.out_data !== 20'h1FFDC) begin errors++; $display("FAIL wrap_data got %0h want 1ffdc", b1.out_data); end
      checks++; if (b1.out_count !== 3'd7) begin errors++; $display("FAIL wrap_count got %0d want 7", b1.out_count); end
      b1.out_ready = 1'b1;
      tick();
      b1.out_ready = 1'b0;
   endtask

   task automatic test_reset_midop();
      int cyc;
      for (int i = 0; i < 2; i++) begin
         b0.in_data  = pack4(9, 9, 9, 9);
         b0.in_last  = 1'b0;
         b0.in_valid = 1'b1;
         tick();
      end
      b0.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", b0.out_valid); end
      b0.in_data  = pack4(5, 5, 5, 5);
      b0.in_last  = 1'b1;
      b0.in_valid = 1'b1;
      tick();
      b0.in_valid = 1'b0;
      b0.in_last  = 1'b0;
      wait_out(0, cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL midrst_timeout got %0d want >=0", cyc); end
      checks++; if (b0.out_data !== 32'd20) begin errors++; $display("FAIL midrst_data got %0d want 20", b0.out_data); end
      checks++; if (b0.out_count !== 8'd1) begin errors++; $display("FAIL midrst_count got %0d want 1", b0.out_count); end
      b0.out_ready = 1'b1;
      tick();
      b0.out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
      b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_wrap_saturate();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
